// File: rtl/wb_bypass_driver.sv
// wb_bypass_driver
// Writeback collector: buffers completed results from four execution units in
// small per-unit FIFOs and drives up to two of them per cycle, round-robin,
// onto the registered bypass / register-file write buses.
module wb_bypass_driver #(
    parameter int WIDTH_REG = 5,
    parameter int DEPTH     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_valid0,
    input  logic                   i_valid1,
    input  logic                   i_valid2,
    input  logic                   i_valid3,
    output logic                   o_ready0,
    output logic                   o_ready1,
    output logic                   o_ready2,
    output logic                   o_ready3,
    input  logic [WIDTH_REG+31:0]  i_result0,
    input  logic [WIDTH_REG+31:0]  i_result1,
    input  logic [WIDTH_REG+31:0]  i_result2,
    input  logic [WIDTH_REG+31:0]  i_result3,
    output logic [WIDTH_REG+32:0]  o_bypass0,
    output logic [WIDTH_REG+32:0]  o_bypass1
);

    localparam int RW = WIDTH_REG + 32;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [RW-1:0] r_mem   [4][DEPTH];
    logic [PW-1:0] r_wptr  [4];
    logic [PW-1:0] r_rptr  [4];
    logic [CW-1:0] r_count [4];
    logic [1:0]    r_rr;

    logic [3:0]    w_valid;
    logic [3:0]    w_ready;
    logic [3:0]    w_push;
    logic [3:0]    w_pop;
    logic [3:0]    w_nempty;
    logic [RW-1:0] w_result [4];

    logic          w_gnt_a;
    logic          w_gnt_b;
    logic [1:0]    w_idx_a;
    logic [1:0]    w_idx_b;
    logic [1:0]    w_scan;
    logic [RW-1:0] w_head_a;
    logic [RW-1:0] w_head_b;
    logic [RW:0]   w_out_a;
    logic [RW:0]   w_out_b;

    assign w_valid     = {i_valid3, i_valid2, i_valid1, i_valid0};
    assign w_result[0] = i_result0;
    assign w_result[1] = i_result1;
    assign w_result[2] = i_result2;
    assign w_result[3] = i_result3;

    assign o_ready0 = w_ready[0];
    assign o_ready1 = w_ready[1];
    assign o_ready2 = w_ready[2];
    assign o_ready3 = w_ready[3];

    // Per-unit ready, push and non-empty status
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_ready[k]  = (r_count[k] < CW'(DEPTH)) && !i_flush;
            w_push[k]   = w_valid[k] && w_ready[k];
            w_nempty[k] = (r_count[k] != '0);
        end
    end

    // Round-robin scan from r_rr: first non-empty unit is grant A, second is grant B
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        w_idx_a = 2'd0;
        w_idx_b = 2'd0;
        w_scan  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_scan = r_rr + 2'(i);
            if (w_nempty[w_scan]) begin
                if (!w_gnt_a) begin
                    w_gnt_a = 1'b1;
                    w_idx_a = w_scan;
                end else if (!w_gnt_b) begin
                    w_gnt_b = 1'b1;
                    w_idx_b = w_scan;
                end
            end
        end
    end

    // Pop decode and bus formatting; rd==0 still consumes its slot but drives zeros
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_pop[k] = (w_gnt_a && (w_idx_a == 2'(k))) || (w_gnt_b && (w_idx_b == 2'(k)));
        end
        w_head_a = r_mem[w_idx_a][r_rptr[w_idx_a]];
        w_head_b = r_mem[w_idx_b][r_rptr[w_idx_b]];
        w_out_a  = '0;
        w_out_b  = '0;
        if (w_gnt_a && (w_head_a[RW-1 -: WIDTH_REG] != '0)) begin
            w_out_a = {1'b1, w_head_a};
        end
        if (w_gnt_b && (w_head_b[RW-1 -: WIDTH_REG] != '0)) begin
            w_out_b = {1'b1, w_head_b};
        end
    end

    // FIFO storage; stale entries are harmless because count gates every read
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (w_push[k]) begin
                r_mem[k][r_wptr[k]] <= w_result[k];
            end
        end
    end

    // FIFO pointers and occupancy; flush empties everything like reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst || i_flush) begin
                r_wptr[k]  <= '0;
                r_rptr[k]  <= '0;
                r_count[k] <= '0;
            end else begin
                if (w_push[k]) begin
                    r_wptr[k] <= r_wptr[k] + PW'(1);
                end
                if (w_pop[k]) begin
                    r_rptr[k] <= r_rptr[k] + PW'(1);
                end
                r_count[k] <= r_count[k] + CW'(w_push[k]) - CW'(w_pop[k]);
            end
        end
    end

    // Registered bypass buses and round-robin pointer; flush keeps r_rr
    always_ff @(posedge clk) begin
        if (rst) begin
            o_bypass0 <= '0;
            o_bypass1 <= '0;
            r_rr      <= 2'd0;
        end else if (i_flush) begin
            o_bypass0 <= '0;
            o_bypass1 <= '0;
        end else begin
            o_bypass0 <= w_out_a;
            o_bypass1 <= w_out_b;
            if (w_gnt_b) begin
                r_rr <= w_idx_b + 2'd1;
            end else if (w_gnt_a) begin
                r_rr <= w_idx_a + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_bypass_driver.sv
// Testbench for wb_bypass_driver: directed vectors with a scoreboard queue of
// expected output-slot pairs, popped by a monitor whenever a bus is valid.
module tb_wb_bypass_driver;

    localparam int WR = 5;
    localparam int RW = WR + 32;
    localparam int BW = WR + 33;

    typedef struct packed {
        logic [BW-1:0] b0;
        logic [BW-1:0] b1;
    } pair_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          tb_valid [4];
    logic [RW-1:0] tb_res   [4];
    logic [3:0]    rdy;
    logic [BW-1:0] byp0;
    logic [BW-1:0] byp1;

    pair_t q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    wb_bypass_driver #(.WIDTH_REG(WR), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (flush),
        .i_valid0  (tb_valid[0]),
        .i_valid1  (tb_valid[1]),
        .i_valid2  (tb_valid[2]),
        .i_valid3  (tb_valid[3]),
        .o_ready0  (rdy[0]),
        .o_ready1  (rdy[1]),
        .o_ready2  (rdy[2]),
        .o_ready3  (rdy[3]),
        .i_result0 (tb_res[0]),
        .i_result1 (tb_res[1]),
        .i_result2 (tb_res[2]),
        .i_result3 (tb_res[3]),
        .o_bypass0 (byp0),
        .o_bypass1 (byp1)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] ex(input logic [WR-1:0] rd, input logic [31:0] d);
        return (rd == '0) ? '0 : {1'b1, rd, d};
    endfunction

    function automatic logic [31:0] mk(input int k, input int seq);
        return {8'(8'hB0 + k), 8'h00, 16'(seq)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_valids();
        for (int k = 0; k < 4; k++) tb_valid[k] = 1'b0;
    endtask

    task automatic drive(input int k, input logic [WR-1:0] rd, input logic [31:0] d);
        tb_valid[k] = 1'b1;
        tb_res[k]   = {rd, d};
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        chk({name, "_drained"}, 64'(q.size()), 64'd0);
        q.delete();
    endtask

    // Monitor: every valid output cycle must match the next expected slot pair
    always @(negedge clk) begin
        pair_t p;
        if (!rst && (byp0[BW-1] || byp1[BW-1])) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got %h / %h expected none", byp0, byp1);
            end else begin
                p = q.pop_front();
                chk("bypass0", 64'(byp0), 64'(p.b0));
                chk("bypass1", 64'(byp1), 64'(p.b1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  seq [4];
        bit  acc [4];
        bit  saw_full;
        rst   = 1'b1;
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tb_valid[k] = 1'b0;
            tb_res[k]   = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset then idle
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_bypass", 64'({byp0, byp1}), 64'd0);
            chk("idle_ready", 64'(rdy), 64'hF);
        end

        // single result from unit 2, rr 0 -> 3
        tick();
        drive(2, 5'd7, 32'hDEADBEEF);
        q.push_back('{b0: ex(5'd7, 32'hDEADBEEF), b1: '0});
        tick();
        clear_valids();
        @(negedge clk);
        chk("single_not_early", 64'(byp0), 64'd0);
        tick();
        @(negedge clk);
        chk("single_latency", 64'(byp0), 64'(ex(5'd7, 32'hDEADBEEF)));
        drain("single");

        // rr==3: units 0 and 3 together -> unit 3 in slot 0; rr -> 1
        tick();
        drive(0, 5'd12, 32'h0000AAAA);
        drive(3, 5'd11, 32'h00003333);
        q.push_back('{b0: ex(5'd11, 32'h00003333), b1: ex(5'd12, 32'h0000AAAA)});
        tick();
        clear_valids();
        drain("rr_wrap");

        // unit 3 alone -> rr back to 0
        tick();
        drive(3, 5'd13, 32'h00003131);
        q.push_back('{b0: ex(5'd13, 32'h00003131), b1: '0});
        tick();
        clear_valids();
        drain("rr_u3");

        // contention: all four units at once with rr==0
        tick();
        for (int k = 0; k < 4; k++) drive(k, 5'(k + 1), 32'hC0000000 + 32'(k));
        q.push_back('{b0: ex(5'd1, 32'hC0000000), b1: ex(5'd2, 32'hC0000001)});
        q.push_back('{b0: ex(5'd3, 32'hC0000002), b1: ex(5'd4, 32'hC0000003)});
        tick();
        clear_valids();
        drain("contention");

        // backpressure: every unit streams 4 sequenced results
        for (int j = 0; j < 8; j++) begin
            if (j % 2 == 0)
                q.push_back('{b0: ex(5'd8, mk(0, j / 2)), b1: ex(5'd9, mk(1, j / 2))});
            else
                q.push_back('{b0: ex(5'd10, mk(2, j / 2)), b1: ex(5'd11, mk(3, j / 2))});
        end
        for (int k = 0; k < 4; k++) seq[k] = 0;
        saw_full = 1'b0;
        tick();
        for (int c = 0; c < 40; c++) begin
            if (seq[0] == 4 && seq[1] == 4 && seq[2] == 4 && seq[3] == 4) break;
            for (int k = 0; k < 4; k++) begin
                tb_valid[k] = (seq[k] < 4);
                tb_res[k]   = {5'(8 + k), mk(k, seq[k])};
            end
            @(negedge clk);
            for (int k = 0; k < 4; k++) acc[k] = tb_valid[k] && rdy[k];
            if (!rdy[0]) saw_full = 1'b1;
            tick();
            for (int k = 0; k < 4; k++) if (acc[k]) seq[k]++;
        end
        clear_valids();
        chk("bp_accepted", 64'(seq[0] + seq[1] + seq[2] + seq[3]), 64'd16);
        chk("bp_ready0_dropped", 64'(saw_full), 64'd1);
        drain("backpressure");

        // zero register: unit 1 rd=0 takes slot 0 as zeros, unit 2 in slot 1; rr -> 3
        tick();
        drive(1, 5'd0, 32'd5);
        drive(2, 5'd14, 32'h00002222);
        q.push_back('{b0: '0, b1: ex(5'd14, 32'h00002222)});
        tick();
        clear_valids();
        tick();
        @(negedge clk);
        chk("zero_slot0", 64'(byp0), 64'd0);
        drain("zero");
        chk("zero_ready1", 64'(rdy[1]), 64'd1);

        // confirm rr advanced past the zero-rd grant
        tick();
        drive(0, 5'd15, 32'h00000F0F);
        drive(3, 5'd16, 32'h00003F3F);
        q.push_back('{b0: ex(5'd16, 32'h00003F3F), b1: ex(5'd15, 32'h00000F0F)});
        tick();
        clear_valids();
        drain("zero_rr");

        // flush with three buffered results and a concurrent push
        tick();
        for (int k = 0; k < 3; k++) drive(k, 5'(17 + k), 32'hF1000000 + 32'(k));
        tick();
        clear_valids();
        flush = 1'b1;
        drive(3, 5'd20, 32'hBAD00003);
        @(negedge clk);
        chk("flush_ready_low", 64'(rdy), 64'h0);
        tick();
        flush = 1'b0;
        clear_valids();
        @(negedge clk);
        chk("flush_bypass_zero", 64'({byp0, byp1}), 64'd0);
        chk("flush_ready_high", 64'(rdy), 64'hF);
        repeat (5) @(negedge clk);

        // post-flush: a fresh result must come out, not stale FIFO contents
        tick();
        drive(0, 5'd21, 32'h12345678);
        q.push_back('{b0: ex(5'd21, 32'h12345678), b1: '0});
        tick();
        clear_valids();
        drain("post_flush");

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
